mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_arb_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE_I,
    DONE_D
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection between instruction and data requesters.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the side not granted last; otherwise data wins.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  grant_e last_grant,
`endif
  output logic   any_req,
  output grant_e grant
);

  always_comb begin
    any_req = i_req | d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else begin
      grant = d_req ? GNT_D : GNT_I;
    end
`else
    grant = d_req ? GNT_D : GNT_I;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction and data requesters onto one memory port.
// MEM_ARB_ROUND_ROBIN_EN compiles in a last-grant register for round-robin ties.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  arb_state_e        state_q, state_d;
  logic              held_q, held_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;
  logic [DATA_W-1:0] i_readdata_q, i_readdata_d;
  logic [DATA_W-1:0] d_readdata_q, d_readdata_d;
  logic              d_req;
  logic              any_req;
  grant_e            grant;

  assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  grant_e last_grant_q, last_grant_d;

  arb_pick u_arb_pick (
    .i_req      (i_read),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .any_req    (any_req),
    .grant      (grant)
  );
`else
  arb_pick u_arb_pick (
    .i_req   (i_read),
    .d_req   (d_req),
    .any_req (any_req),
    .grant   (grant)
  );
`endif

  always_comb begin
    state_d         = state_q;
    held_d          = held_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    i_readdata_d    = i_readdata_q;
    d_readdata_d    = d_readdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d    = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          held_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = grant;
`endif
          if (grant == GNT_D) begin
            state_d         = SERVE_D;
            mem_address_d   = d_address;
            mem_writedata_d = d_writedata;
            // A simultaneous read and write is issued as a write.
            mem_write_d     = d_write;
            mem_read_d      = d_read & ~d_write;
          end else begin
            state_d       = SERVE_I;
            mem_address_d = i_address;
            mem_read_d    = 1'b1;
            mem_write_d   = 1'b0;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        // held_q guarantees at least two cycles of command before completion.
        if (held_q && !mem_busywait) begin
          state_d     = (state_q == SERVE_I) ? DONE_I : DONE_D;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) begin
            if (state_q == SERVE_I) begin
              i_readdata_d = mem_readdata;
            end else begin
              d_readdata_d = mem_readdata;
            end
          end
        end else begin
          held_d = 1'b1;
        end
      end
      DONE_I, DONE_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= IDLE;
      held_q          <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      i_readdata_q    <= '0;
      d_readdata_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q    <= GNT_I;
`endif
    end else begin
      state_q         <= state_d;
      held_q          <= held_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      i_readdata_q    <= i_readdata_d;
      d_readdata_q    <= d_readdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q    <= last_grant_d;
`endif
    end
  end

  always_comb begin
    i_busywait = i_read && (state_q != DONE_I);
    d_busywait = d_req && (state_q != DONE_D);
  end

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign i_readdata    = i_readdata_q;
  assign d_readdata    = d_readdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 4-busy-cycle memory model.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        i_read, d_read, d_write;
  logic [5:0]  i_address, d_address;
  logic [31:0] d_writedata;
  logic [31:0] i_readdata, d_readdata;
  logic        i_busywait, d_busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_busywait;

  logic [31:0] mem_model [0:63];
  int unsigned cmd_cnt = 0;

  typedef struct packed {
    logic        side_d;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t        sb[$];
  int          rise_cyc[$];
  int          done_cyc[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          mem_hi, lo_i, first_done;
  logic [31:0] i_rd_exp = '0;
  logic [31:0] d_rd_exp = '0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .i_read        (i_read),
    .i_address     (i_address),
    .i_readdata    (i_readdata),
    .i_busywait    (i_busywait),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_address     (d_address),
    .d_writedata   (d_writedata),
    .d_readdata    (d_readdata),
    .d_busywait    (d_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  // Memory holds busywait for the first 4 cycles of each command.
  always @(posedge CLK) begin
    if (mem_read || mem_write) cmd_cnt <= cmd_cnt + 1;
    else cmd_cnt <= 0;
  end
  assign mem_busywait = (mem_read || mem_write) && (cmd_cnt < 4);
  assign mem_readdata = mem_model[mem_address];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic side_d, input logic wr, input logic [5:0] addr,
                      input logic [31:0] wdata);
    txn_t t;
    t.side_d = side_d;
    t.wr     = wr;
    t.addr   = addr;
    t.data   = wr ? wdata : mem_model[addr];
    sb.push_back(t);
  endtask

  task automatic complete(input logic side_d);
    txn_t e;
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("served_side", 32'(side_d), 32'(e.side_d));
      if (!e.wr) begin
        if (e.side_d) d_rd_exp = e.data;
        else i_rd_exp = e.data;
      end
      check_eq("i_readdata", i_readdata, i_rd_exp);
      check_eq("d_readdata", d_readdata, d_rd_exp);
    end
    done_cyc.push_back(cyc);
  endtask

  task automatic serve_all(input int budget);
    int   n;
    logic cmd, prev_cmd, drop_i, drop_d;
    n = 0; prev_cmd = 1'b0; mem_hi = 0; lo_i = 0; first_done = -1;
    rise_cyc.delete();
    done_cyc.delete();
    while ((i_read || d_read || d_write) && n < budget) begin
      @(negedge CLK);
      n++; cyc++;
      cmd = mem_read | mem_write;
      if (cmd && !prev_cmd) rise_cyc.push_back(cyc);
      prev_cmd = cmd;
      if (cmd) begin
        mem_hi++;
        if (sb.size() > 0) begin
          check_eq("mem_write", 32'(mem_write), 32'(sb[0].wr));
          check_eq("mem_read", 32'(mem_read), 32'(!sb[0].wr));
          check_eq("mem_address", 32'(mem_address), 32'(sb[0].addr));
          if (sb[0].wr) check_eq("mem_writedata", mem_writedata, sb[0].data);
        end else begin
          check_eq("unexpected_cmd", 32'd1, 32'd0);
        end
      end
      drop_i = 1'b0;
      drop_d = 1'b0;
      if (i_read && !i_busywait) begin
        lo_i++;
        if (first_done < 0) first_done = n;
        complete(1'b0);
        drop_i = 1'b1;
      end
      if ((d_read || d_write) && !d_busywait) begin
        if (first_done < 0) first_done = n;
        complete(1'b1);
        drop_d = 1'b1;
      end
      @(posedge CLK);
      #1;
      if (drop_i) i_read = 1'b0;
      if (drop_d) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    end
    if (i_read || d_read || d_write) begin
      check_eq("timeout", 32'd1, 32'd0);
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
  endtask

  task automatic check_gap(input string tag);
    if (rise_cyc.size() < 2 || done_cyc.size() < 1) check_eq(tag, 32'd0, 32'd2);
    else check_eq(tag, 32'(rise_cyc[1] - done_cyc[0]), 32'd2);
  endtask

  initial begin
    RESET = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0;
    for (int k = 0; k < 64; k++) mem_model[k] = $urandom | 32'h1;
    mem_model[5] = 32'hA1B2C3D4;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    check_eq("rst_mem_write", 32'(mem_write), 32'd0);
    check_eq("rst_mem_address", 32'(mem_address), 32'd0);
    check_eq("rst_mem_writedata", mem_writedata, 32'd0);
    check_eq("rst_i_readdata", i_readdata, 32'd0);
    check_eq("rst_d_readdata", d_readdata, 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b0;

    // Single instruction read: 5 command cycles, 7 cycles to completion.
    i_address = 6'd5; i_read = 1'b1;
    push(1'b0, 1'b0, 6'd5, '0);
    serve_all(40);
    check_eq("i_lat", 32'(first_done), 32'd7);
    check_eq("i_mem_read_cycles", 32'(mem_hi), 32'd5);
    check_eq("i_busy_low_cycles", 32'(lo_i), 32'd1);
    check_eq("i_readdata_a1", i_readdata, 32'hA1B2C3D4);

    // Data write leaves d_readdata alone.
    d_address = 6'd3; d_writedata = 32'h55; d_write = 1'b1;
    push(1'b1, 1'b1, 6'd3, 32'h55);
    serve_all(40);

    // Read+write together is a write.
    d_address = 6'd9; d_writedata = 32'hDEADBEEF; d_read = 1'b1; d_write = 1'b1;
    push(1'b1, 1'b1, 6'd9, 32'hDEADBEEF);
    serve_all(40);

    // Tie after a data grant.
    i_address = 6'd10; d_address = 6'd20; i_read = 1'b1; d_read = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push(1'b0, 1'b0, 6'd10, '0);
    push(1'b1, 1'b0, 6'd20, '0);
`else
    push(1'b1, 1'b0, 6'd20, '0);
    push(1'b0, 1'b0, 6'd10, '0);
`endif
    serve_all(80);
    check_gap("tie1_gap");

    // Instruction-only grant, then a second tie.
    i_address = 6'd11; i_read = 1'b1;
    push(1'b0, 1'b0, 6'd11, '0);
    serve_all(40);
    i_address = 6'd12; d_address = 6'd21; i_read = 1'b1; d_read = 1'b1;
    push(1'b1, 1'b0, 6'd21, '0);
    push(1'b0, 1'b0, 6'd12, '0);
    serve_all(80);
    check_gap("tie2_gap");

    // Reset in the second SERVE_D cycle abandons the access.
    d_address = 6'd7; d_read = 1'b1;
    @(negedge CLK);
    check_eq("rr_busy_idle", 32'(d_busywait), 32'd1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check_eq("rr_mem_read_serve", 32'(mem_read), 32'd1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check_eq("rr_mem_read_after", 32'(mem_read), 32'd0);
    check_eq("rr_d_readdata", d_readdata, 32'd0);
    check_eq("rr_i_readdata", i_readdata, 32'd0);
    check_eq("rr_d_busywait", 32'(d_busywait), 32'd1);
    i_rd_exp = '0;
    d_rd_exp = '0;
    push(1'b1, 1'b0, 6'd7, '0);
    serve_all(40);
    check_eq("rr_reserved", d_readdata, mem_model[7]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
